// File: rtl/div_seq.sv
// div_seq: multi-cycle unsigned restoring divider controller (DIVU).
// It drives an external combinational subtractor once per cycle and keeps
// the partial remainder / quotient registers. Remainder goes to HI, quotient to LO.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_r,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           stateReg;
  state_t           stateNext;
  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] rReg;
  logic [WIDTH-1:0] dReg;
  logic [CW-1:0]    countReg;
  logic             dbzReg;

  logic [WIDTH-1:0] shifted;
  logic             outBit;
  logic             borrow;
  logic             takeDiff;
  logic             divisorZero;

  // Shift the next dividend bit into the partial remainder; the bit shifted
  // out of R is a hidden 2^WIDTH weight that guarantees the subtraction fits.
  assign shifted     = {rReg[WIDTH-2:0], qReg[WIDTH-1]};
  assign outBit      = rReg[WIDTH-1];
  // Borrow of S - D recovered from operand and result sign bits only, since
  // the external subtractor exposes no carry.
  assign borrow      = (~shifted[WIDTH-1] & dReg[WIDTH-1]) |
                       (~(shifted[WIDTH-1] ^ dReg[WIDTH-1]) & sub_r[WIDTH-1]);
  assign takeDiff    = outBit | ~borrow;
  assign divisorZero = (divisor == '0);

  assign quotient    = qReg;
  assign remainder   = rReg;
  assign div_by_zero = dbzReg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic: divide-by-zero skips RUN entirely
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (start) begin
          stateNext = divisorZero ? DONE : RUN;
        end
      end
      RUN: begin
        if (countReg == '0) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs: subtractor operands are only live in RUN, zero otherwise
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    sub_a = '0;
    sub_b = '0;
    case (stateReg)
      RUN: begin
        busy  = 1'b1;
        sub_a = shifted;
        sub_b = dReg;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture on accepted start, one quotient bit per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qReg     <= '0;
      rReg     <= '0;
      dReg     <= '0;
      countReg <= '0;
      dbzReg   <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            if (divisorZero) begin
              qReg   <= '1;
              rReg   <= dividend;
              dbzReg <= 1'b1;
            end else begin
              dReg     <= divisor;
              qReg     <= dividend;
              rReg     <= '0;
              countReg <= CW'(WIDTH - 1);
              dbzReg   <= 1'b0;
            end
          end
        end
        RUN: begin
          if (takeDiff) begin
            rReg <= sub_r;
            qReg <= {qReg[WIDTH-2:0], 1'b1};
          end else begin
            rReg <= shifted;
            qReg <= {qReg[WIDTH-2:0], 1'b0};
          end
          if (countReg != '0) begin
            countReg <= countReg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
